egress_pkt_buffer: RTL
======================

// Module: egress_pkt_buffer
// PURPOSE
//  Store-and-forward packet FIFO sitting directly upstream of the NoC output/sink stage.
//  Accepts flits from the router egress port (AXI-Stream slave) and holds each packet.
//  Releases a packet on the AXI-Stream master only once its TLAST flit is buffered, so the sink sees gap-free packets.
//  Also reports occupancy and packet counts for bench/DONE monitoring.
// PARAMETERS
//  TDATAW  32  flit data width
//  TDESTW   4  destination field width
//  TIDW     2  source ID field width
//  DEPTH   16  flit entries; power of 2, >= 2
// PORTS
//  CLK            in   1                    single clock, all logic posedge
//  RST            in   1                    synchronous reset, active-high
//  AXIS_S_TVALID  in   1                    upstream flit valid
//  AXIS_S_TREADY  out  1                    buffer can accept a flit
//  AXIS_S_TDATA   in   TDATAW               flit data
//  AXIS_S_TLAST   in   1                    last flit of packet
//  AXIS_S_TID     in   TIDW                 source ID
//  AXIS_S_TDEST   in   TDESTW               destination
//  AXIS_M_TVALID  out  1                    flit available to sink
//  AXIS_M_TREADY  in   1                    sink accepts flit
//  AXIS_M_TDATA   out  TDATAW               head flit data
//  AXIS_M_TLAST   out  1                    head flit last
//  AXIS_M_TID     out  TIDW                 head flit ID
//  AXIS_M_TDEST   out  TDESTW               head flit dest
//  FLIT_COUNT     out  $clog2(DEPTH)+1      flits stored
//  PKT_COUNT      out  $clog2(DEPTH)+1      complete packets stored
//  OVERSIZE       out  1                    sticky: cut-through fallback has occurred
//  STAT_PKTS_IN   out  32                   packets accepted (PKT_STATS_EN)
//  STAT_PKTS_OUT  out  32                   packets emitted (PKT_STATS_EN)
// BEHAVIOUR
//  - Clocking/reset: CLK only; RST synchronous, active-high. On RST: pointers, FLIT_COUNT, PKT_COUNT, OVERSIZE, cut-through flag, stats = 0.
//    Reset mid-packet discards all buffered flits, including partial packets.
//    While RST is high: AXIS_S_TREADY=0, AXIS_M_TVALID=0.
//  - Push: when AXIS_S_TVALID && AXIS_S_TREADY. AXIS_S_TREADY = !RST && FLIT_COUNT!=DEPTH.
//    Full blocks push even if a pop happens in the same cycle.
//  - Pop: when AXIS_M_TVALID && AXIS_M_TREADY. Master fields are driven first-word-fall-through from the head entry.
//    Master fields are stable while TVALID && !TREADY.
//  - AXIS_M_TVALID = FLIT_COUNT!=0 && (PKT_COUNT!=0 || cut_thru).
//    Latency: a 1-flit packet accepted in cycle N is valid in cycle N+1.
//  - PKT_COUNT: +1 on a push with TLAST, -1 on a pop with TLAST; both in the same cycle = unchanged.
//    FLIT_COUNT: same rule for push/pop.
//  - Pointers: log2(DEPTH) bits, wrap naturally modulo DEPTH.
//  - Oversize packet (longer than DEPTH): when FLIT_COUNT==DEPTH && PKT_COUNT==0, set cut_thru and OVERSIZE.
//    In cut_thru, flits stream out as stored. cut_thru clears on the pop of a TLAST flit. OVERSIZE stays set until RST.
//  - Unflagged packets are never interleaved. Output order equals input order.
// CONFIGURATION
//  PKT_STATS_EN defined: STAT_PKTS_IN/STAT_PKTS_OUT are 32-bit counters.
//    They increment on TLAST push/pop, wrap at 2^32, and are cleared by RST.
//  PKT_STATS_EN undefined: both ports are tied to 0 and no counter flops exist.
// TESTING
//  1. RST high 3 cycles with S_TVALID=1 -> S_TREADY=0, M_TVALID=0, all counts 0.
//  2. Push 4-flit packet (data 0x10..0x13, dest 0x3, id 0x1), M_TREADY=1 -> M_TVALID=0 until cycle after TLAST push.
//     Then 4 consecutive flits out in order; PKT_COUNT goes 1 then 0.
//  3. M_TREADY=0, push 16 single-flit packets -> FLIT_COUNT=16, PKT_COUNT=16, S_TREADY=0.
//     Push+pop in the same cycle while full -> no push occurs; FLIT_COUNT=15.
//  4. 20-flit packet with DEPTH=16 -> OVERSIZE=1 at FLIT_COUNT=16; all 20 flits are delivered.
//     cut_thru clears after TLAST pop; next normal packet is held until its TLAST.
//  5. Assert RST after 2 flits of a 5-flit packet -> next cycle FLIT_COUNT=0.
//     A following 1-flit packet (0xAA) is delivered alone.
//  6. PKT_STATS_EN build, 7 packets through -> STAT_PKTS_IN=7, STAT_PKTS_OUT=7. Non-EN build -> both 0.

Source files
------------

// File: rtl/egress_pkt_buffer.sv
// rtl/egress_pkt_buffer.sv - store-and-forward egress packet FIFO with cut-through fallback for oversize packets
// Optional feature macro: PKT_STATS_EN (32-bit packets-in/packets-out counters)
module egress_pkt_buffer #(
    parameter int TDATAW = 32,
    parameter int TDESTW = 4,
    parameter int TIDW   = 2,
    parameter int DEPTH  = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     AXIS_S_TVALID,
    output logic                     AXIS_S_TREADY,
    input  logic [TDATAW-1:0]        AXIS_S_TDATA,
    input  logic                     AXIS_S_TLAST,
    input  logic [TIDW-1:0]          AXIS_S_TID,
    input  logic [TDESTW-1:0]        AXIS_S_TDEST,
    output logic                     AXIS_M_TVALID,
    input  logic                     AXIS_M_TREADY,
    output logic [TDATAW-1:0]        AXIS_M_TDATA,
    output logic                     AXIS_M_TLAST,
    output logic [TIDW-1:0]          AXIS_M_TID,
    output logic [TDESTW-1:0]        AXIS_M_TDEST,
    output logic [$clog2(DEPTH):0]   FLIT_COUNT,
    output logic [$clog2(DEPTH):0]   PKT_COUNT,
    output logic                     OVERSIZE,
    output logic [31:0]              STAT_PKTS_IN,
    output logic [31:0]              STAT_PKTS_OUT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [TDATAW-1:0] r_data [DEPTH];
    logic              r_last [DEPTH];
    logic [TIDW-1:0]   r_id   [DEPTH];
    logic [TDESTW-1:0] r_dest [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_flit_count;
    logic [CW-1:0] r_pkt_count;
    logic          r_cut_thru;
    logic          r_oversize;

    logic w_push;
    logic w_pop;
    logic w_push_last;
    logic w_pop_last;

    // A full buffer holding no complete packet can never release anything; stream it out instead.
    assign AXIS_S_TREADY = !RST && (r_flit_count != FULL_CNT);
    assign AXIS_M_TVALID = !RST && (r_flit_count != '0) && ((r_pkt_count != '0) || r_cut_thru);

    assign w_push      = AXIS_S_TVALID && AXIS_S_TREADY;
    assign w_pop       = AXIS_M_TVALID && AXIS_M_TREADY;
    assign w_push_last = w_push && AXIS_S_TLAST;
    assign w_pop_last  = w_pop && AXIS_M_TLAST;

    assign AXIS_M_TDATA = r_data[r_rd_ptr];
    assign AXIS_M_TLAST = r_last[r_rd_ptr];
    assign AXIS_M_TID   = r_id[r_rd_ptr];
    assign AXIS_M_TDEST = r_dest[r_rd_ptr];

    assign FLIT_COUNT = r_flit_count;
    assign PKT_COUNT  = r_pkt_count;
    assign OVERSIZE   = r_oversize;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= AXIS_S_TDATA;
            r_last[r_wr_ptr] <= AXIS_S_TLAST;
            r_id[r_wr_ptr]   <= AXIS_S_TID;
            r_dest[r_wr_ptr] <= AXIS_S_TDEST;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_flit_count <= '0;
            r_pkt_count  <= '0;
            r_cut_thru   <= 1'b0;
            r_oversize   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_flit_count <= r_flit_count + CW'(w_push) - CW'(w_pop);
            r_pkt_count  <= r_pkt_count + CW'(w_push_last) - CW'(w_pop_last);
            if (w_pop_last) begin
                r_cut_thru <= 1'b0;
            end else if ((r_flit_count == FULL_CNT) && (r_pkt_count == '0)) begin
                r_cut_thru <= 1'b1;
                r_oversize <= 1'b1;
            end
        end
    end

`ifdef PKT_STATS_EN
    logic [31:0] r_stat_in;
    logic [31:0] r_stat_out;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stat_in  <= '0;
            r_stat_out <= '0;
        end else begin
            r_stat_in  <= r_stat_in + 32'(w_push_last);
            r_stat_out <= r_stat_out + 32'(w_pop_last);
        end
    end

    assign STAT_PKTS_IN  = r_stat_in;
    assign STAT_PKTS_OUT = r_stat_out;
`else
    assign STAT_PKTS_IN  = '0;
    assign STAT_PKTS_OUT = '0;
`endif

endmodule
